ascii_num_parser: RTL and testbench
===================================

ASCII_NUM_PARSER -- requirements
Module: ascii_num_parser

Interface
REQ-001 Parameter DIGITS_MAX, default 8: maximum digits accepted per number, range 1..16.
REQ-002 Parameter OUT_WIDTH, default 32: result width in bits, range 4..64.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mode_hex_in  input  1  radix select: 0 = decimal, 1 = hexadecimal.
REQ-006 ascii_char_in  input  8  input character.
REQ-007 valid_in  input  1  ascii_char_in is valid.
REQ-008 ready_in  output  1  parser accepts a character this cycle.
REQ-009 value_out  output  OUT_WIDTH  parsed binary value.
REQ-010 digit_count_out  output  $clog2(DIGITS_MAX+1)  digits accepted for the word.
REQ-011 err_char_out  output  1  word contained an illegal character.
REQ-012 err_ovf_out  output  1  word exceeded DIGITS_MAX digits or OUT_WIDTH range.
REQ-013 valid_out  output  1  result fields are valid.
REQ-014 ready_out  input  1  consumer accepts the result.
REQ-015 busy_out  output  1  a word is in progress or a result is pending.

Function
REQ-016 A character is accepted when valid_in and ready_in are both 1 on a rising edge.
REQ-017 Terminators: 0x0D, 0x0A, 0x20; digits: 0x30-0x39, plus 0x41-0x46 and 0x61-0x66 when in hex mode.
REQ-018 FSM states: IDLE, ACCUM, FLUSH, DONE.
REQ-019 IDLE: accepted terminator ignored; digit loads accumulator with its value, count=1, latches mode, goes to ACCUM; illegal character sets err_char, goes to FLUSH.
REQ-020 Radix is latched on the first digit; mode_hex_in changes mid-word have no effect until the next word.
REQ-021 ACCUM digit: decimal acc = acc*10 + d, hex acc = (acc<<4) | d, count increments.
REQ-022 Arithmetic uses OUT_WIDTH+4 internal bits; any result above 2^OUT_WIDTH-1, or count exceeding DIGITS_MAX, sets err_ovf and goes to FLUSH.
REQ-023 ACCUM illegal character: sets err_char, goes to FLUSH.
REQ-024 FLUSH: discards characters until a terminator is accepted.
REQ-025 Terminator accepted in ACCUM or FLUSH: result registered, goes to DONE; valid_out is 1 on the next cycle (latency 1).
REQ-026 With any error flag set, value_out = 0; digit_count_out = digits accepted before the error.
REQ-027 DONE: ready_in = 0, outputs held stable; on valid_out && ready_out, goes to IDLE and valid_out drops next cycle.
REQ-028 ready_in = 1 in IDLE, ACCUM and FLUSH.
REQ-029 busy_out = 1 in every state except IDLE.
REQ-030 Error flags are cleared when the next word starts.

Reset
REQ-031 While rst_n = 0: state IDLE; value_out, digit_count_out, err_char_out, err_ovf_out, valid_out and busy_out = 0; ready_in = 0.
REQ-032 Reset mid-word discards the partial word; no result is emitted for it.

Structure
REQ-033 Shared package ascii_pkg holds the FSM state enum, the terminator and character-range constants, and the function char_to_nibble returning {legal, value}.
REQ-034 Single module; no sub-module instance.

Verification
REQ-035 Decimal "1234"+0x0D -> value 0x000004D2, count 4, no error flags, valid_out one cycle after CR is accepted.
REQ-036 Hex "dEaD"+0x0A -> value 0x0000DEAD, count 4; mode_hex_in toggled after 'd' has no effect.
REQ-037 Decimal "12x4"+0x20 -> err_char=1, value 0, count 2; '4' discarded.
REQ-038 Decimal "123456789"+CR (DIGITS_MAX=8) -> err_ovf=1; with OUT_WIDTH=16, "70000"+CR -> err_ovf=1.
REQ-039 ready_out held 0 for 3 cycles after result -> ready_in=0, outputs stable, next character waits; accepted the cycle after handshake.
REQ-040 Feed "12", pulse rst_n low, then "5"+CR -> single result value 5, count 1; leading 0x20 characters are ignored.

Source files
------------

// File: rtl/ascii_pkg.sv
// Shared definitions for the ASCII number parser: FSM states, character
// constants and the character-to-nibble classifier.
package ascii_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_FLUSH,
      ST_DONE
   } state_e;

   localparam logic [7:0] CHAR_CR   = 8'h0D;
   localparam logic [7:0] CHAR_LF   = 8'h0A;
   localparam logic [7:0] CHAR_SP   = 8'h20;
   localparam logic [7:0] DEC_LO    = 8'h30;
   localparam logic [7:0] DEC_HI    = 8'h39;
   localparam logic [7:0] HEX_UC_LO = 8'h41;
   localparam logic [7:0] HEX_UC_HI = 8'h46;
   localparam logic [7:0] HEX_LC_LO = 8'h61;
   localparam logic [7:0] HEX_LC_HI = 8'h66;

   function automatic logic is_terminator(input logic [7:0] c);
      return (c == CHAR_CR) || (c == CHAR_LF) || (c == CHAR_SP);
   endfunction

   // Returns {legal, value}; letters are only legal when hex is set.
   function automatic logic [4:0] char_to_nibble(input logic [7:0] c, input logic hex);
      logic [4:0] r;
      r = '0;
      if (c >= DEC_LO && c <= DEC_HI) begin
         r = {1'b1, 4'(c - DEC_LO)};
      end else if (hex && c >= HEX_UC_LO && c <= HEX_UC_HI) begin
         r = {1'b1, 4'(c - HEX_UC_LO + 8'd10)};
      end else if (hex && c >= HEX_LC_LO && c <= HEX_LC_HI) begin
         r = {1'b1, 4'(c - HEX_LC_LO + 8'd10)};
      end
      return r;
   endfunction

endpackage

// File: rtl/ascii_num_parser.sv
// Streaming ASCII decimal/hex number parser: accumulates digits per word,
// flags illegal characters and overflow, and hands one result per word.
module ascii_num_parser
   import ascii_pkg::*;
#(
   parameter int unsigned DIGITS_MAX = 8,
   parameter int unsigned OUT_WIDTH  = 32
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               mode_hex_in,
   input  logic [7:0]                         ascii_char_in,
   input  logic                               valid_in,
   output logic                               ready_in,
   output logic [OUT_WIDTH-1:0]               value_out,
   output logic [$clog2(DIGITS_MAX+1)-1:0]    digit_count_out,
   output logic                               err_char_out,
   output logic                               err_ovf_out,
   output logic                               valid_out,
   input  logic                               ready_out,
   output logic                               busy_out
);

   localparam int unsigned CW = $clog2(DIGITS_MAX + 1);
   localparam int unsigned AW = OUT_WIDTH + 4;

   state_e               state_q;
   logic [OUT_WIDTH-1:0] acc_q;
   logic [CW-1:0]        cnt_q;
   logic                 hex_q;
   logic                 echar_q;
   logic                 eovf_q;

   logic [OUT_WIDTH-1:0] value_q;
   logic [CW-1:0]        count_q;
   logic                 err_char_q;
   logic                 err_ovf_q;
   logic                 valid_q;
   logic                 busy_q;
   logic                 ready_q;

   logic                 accept;
   logic                 term;
   logic [4:0]           nib;
   logic                 nib_legal;
   logic [3:0]           nib_val;
   logic [AW-1:0]        acc_ext;
   logic [AW-1:0]        acc_nx;
   logic                 sum_ovf;
   logic                 cnt_full;
   logic                 finish_word;

   always_comb begin
      accept    = valid_in && ready_q;
      term      = is_terminator(ascii_char_in);
      // Radix comes from the port only for the first digit of a word.
      nib       = char_to_nibble(ascii_char_in, (state_q == ST_IDLE) ? mode_hex_in : hex_q);
      nib_legal = nib[4];
      nib_val   = nib[3:0];
      acc_ext   = AW'(acc_q);
      acc_nx    = '0;
      if (hex_q) begin
         acc_nx = (acc_ext << 4) | AW'(nib_val);
      end else begin
         acc_nx = acc_ext * AW'(10) + AW'(nib_val);
      end
      sum_ovf     = |acc_nx[AW-1:OUT_WIDTH];
      cnt_full    = (cnt_q == CW'(DIGITS_MAX));
      finish_word = accept && term && ((state_q == ST_ACCUM) || (state_q == ST_FLUSH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         hex_q      <= 1'b0;
         echar_q    <= 1'b0;
         eovf_q     <= 1'b0;
         value_q    <= '0;
         count_q    <= '0;
         err_char_q <= 1'b0;
         err_ovf_q  <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         unique case (state_q)
            ST_IDLE: begin
               if (accept && !term) begin
                  hex_q      <= mode_hex_in;
                  eovf_q     <= 1'b0;
                  err_char_q <= 1'b0;
                  err_ovf_q  <= 1'b0;
                  busy_q     <= 1'b1;
                  if (nib_legal) begin
                     acc_q   <= OUT_WIDTH'(nib_val);
                     cnt_q   <= CW'(1);
                     echar_q <= 1'b0;
                     state_q <= ST_ACCUM;
                  end else begin
                     acc_q   <= '0;
                     cnt_q   <= '0;
                     echar_q <= 1'b1;
                     state_q <= ST_FLUSH;
                  end
               end
            end
            ST_ACCUM: begin
               if (accept && !term) begin
                  if (!nib_legal) begin
                     echar_q <= 1'b1;
                     state_q <= ST_FLUSH;
                  end else if (cnt_full || sum_ovf) begin
                     eovf_q  <= 1'b1;
                     state_q <= ST_FLUSH;
                  end else begin
                     acc_q <= acc_nx[OUT_WIDTH-1:0];
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            ST_FLUSH: begin
            end
            ST_DONE: begin
               if (valid_q && ready_out) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  ready_q <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         // Terminator in ACCUM or FLUSH publishes the word's result.
         if (finish_word) begin
            value_q    <= (echar_q || eovf_q) ? '0 : acc_q;
            count_q    <= cnt_q;
            err_char_q <= echar_q;
            err_ovf_q  <= eovf_q;
            valid_q    <= 1'b1;
            ready_q    <= 1'b0;
            state_q    <= ST_DONE;
         end
      end
   end

   assign ready_in        = ready_q;
   assign value_out       = value_q;
   assign digit_count_out = count_q;
   assign err_char_out    = err_char_q;
   assign err_ovf_out     = err_ovf_q;
   assign valid_out       = valid_q;
   assign busy_out        = busy_q;

endmodule

// File: tb/tb_ascii_num_parser.sv
// Scoreboard bench for ascii_num_parser: two configurations (8 digits/32 bits
// and 5 digits/16 bits) share one character stream and a word-level model.
module tb_ascii_num_parser;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mode_hex_in = 1'b0;
   logic [7:0]  ascii_char_in = 8'h00;
   logic        valid_in = 1'b0;
   logic        ready_out = 1'b0;

   logic        a_ready_in, a_err_char_out, a_err_ovf_out, a_valid_out, a_busy_out;
   logic [31:0] a_value_out;
   logic [3:0]  a_digit_count_out;
   logic        b_ready_in, b_err_char_out, b_err_ovf_out, b_valid_out, b_busy_out;
   logic [15:0] b_value_out;
   logic [2:0]  b_digit_count_out;

   ascii_num_parser #(.DIGITS_MAX(8), .OUT_WIDTH(32)) dut_a (
      .clk(clk), .rst_n(rst_n), .mode_hex_in(mode_hex_in), .ascii_char_in(ascii_char_in),
      .valid_in(valid_in), .ready_in(a_ready_in), .value_out(a_value_out),
      .digit_count_out(a_digit_count_out), .err_char_out(a_err_char_out),
      .err_ovf_out(a_err_ovf_out), .valid_out(a_valid_out), .ready_out(ready_out),
      .busy_out(a_busy_out));

   ascii_num_parser #(.DIGITS_MAX(5), .OUT_WIDTH(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .mode_hex_in(mode_hex_in), .ascii_char_in(ascii_char_in),
      .valid_in(valid_in), .ready_in(b_ready_in), .value_out(b_value_out),
      .digit_count_out(b_digit_count_out), .err_char_out(b_err_char_out),
      .err_ovf_out(b_err_ovf_out), .valid_out(b_valid_out), .ready_out(ready_out),
      .busy_out(b_busy_out));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] value;
      int          count;
      bit          ec;
      bit          eo;
   } exp_t;

   exp_t        qa[$];
   exp_t        qb[$];
   byte unsigned word[$];
   bit          word_hex;
   int          nchk = 0;
   int          nerr = 0;
   bit          hold_rdy = 1'b0;
   int          last_hs = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic bit is_term(byte unsigned c);
      return (c == 8'h0D) || (c == 8'h0A) || (c == 8'h20);
   endfunction

   function automatic int digit_val(byte unsigned c, bit hex);
      if (c >= "0" && c <= "9") return int'(c) - int'("0");
      if (hex && c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
      if (hex && c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
      return -1;
   endfunction

   // Evaluates the buffered word for a given digit limit and result width.
   function automatic exp_t eval_word(int dmax, int ow);
      exp_t        e;
      longint unsigned v = 0;
      longint unsigned nv;
      longint unsigned maxv = (64'd1 << ow) - 1;
      int          d;
      e.ec = 0;
      e.eo = 0;
      e.count = 0;
      for (int i = 0; i < word.size(); i++) begin
         d = digit_val(word[i], word_hex);
         if (d < 0) begin e.ec = 1; break; end
         if (e.count == dmax) begin e.eo = 1; break; end
         nv = v * (word_hex ? 16 : 10) + longint'(d);
         if (nv > maxv) begin e.eo = 1; break; end
         v = nv;
         e.count++;
      end
      e.value = (e.ec || e.eo) ? 64'd0 : v;
      return e;
   endfunction

   function automatic bit model_char(byte unsigned c, bit hex);
      if (is_term(c)) begin
         if (word.size() > 0) begin
            qa.push_back(eval_word(8, 32));
            qb.push_back(eval_word(5, 16));
            word.delete();
            return 1'b1;
         end
         return 1'b0;
      end
      if (word.size() == 0) word_hex = hex;
      word.push_back(c);
      return 1'b0;
   endfunction

   // Called at a falling edge; returns at a falling edge.
   task automatic send_char(input byte unsigned c, input bit hex, output int acc_cyc);
      int waited = 0;
      bit res;
      ascii_char_in = c;
      mode_hex_in   = hex;
      valid_in      = 1'b1;
      while (!(a_ready_in && b_ready_in) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 200) begin
         nchk++;
         nerr++;
         $display("FAIL accept_timeout: char %0h not accepted within 200 cycles", c);
         valid_in = 1'b0;
         acc_cyc  = -1;
         return;
      end
      acc_cyc = cyc + 1;
      res = model_char(c, hex);
      @(negedge clk);
      valid_in = 1'b0;
      if (res) begin
         check("a_latency", a_valid_out, 1);
         check("b_latency", b_valid_out, 1);
      end
   endtask

   task automatic send_str(input string s, input bit hex);
      int ac;
      for (int i = 0; i < s.len(); i++) send_char(s[i], hex, ac);
   endtask

   task automatic check_reset_outputs();
      check("a_rst_value", a_value_out, 0);
      check("a_rst_count", a_digit_count_out, 0);
      check("a_rst_flags", {a_err_char_out, a_err_ovf_out, a_valid_out, a_busy_out, a_ready_in}, 0);
      check("b_rst_value", b_value_out, 0);
      check("b_rst_count", b_digit_count_out, 0);
      check("b_rst_flags", {b_err_char_out, b_err_ovf_out, b_valid_out, b_busy_out, b_ready_in}, 0);
   endtask

   task automatic drain();
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         nchk++;
         nerr++;
         $display("FAIL drain_timeout: %0d/%0d results never presented", qa.size(), qb.size());
      end
   endtask

   function automatic byte unsigned gen_char(bit hex);
      int r = $urandom_range(0, 99);
      byte unsigned bad[6];
      bad[0] = "x"; bad[1] = "g"; bad[2] = "."; bad[3] = ":"; bad[4] = "/"; bad[5] = "G";
      if (r < 4) return bad[$urandom_range(0, 5)];
      if (hex && r < 50) return byte'(($urandom_range(0, 1) ? 8'h61 : 8'h41) + $urandom_range(0, 5));
      return byte'(8'h30 + $urandom_range(0, 9));
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         ready_out = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin : mon_a
      bit pv = 0, pr = 0;
      logic [31:0] pval;
      logic [3:0]  pcnt;
      logic [1:0]  perr;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin pv = 0; continue; end
         if (a_valid_out) begin
            check("a_ready_in_done", a_ready_in, 0);
            check("a_busy_done", a_busy_out, 1);
            if (pv && !pr) begin
               check("a_hold", {a_value_out, a_digit_count_out, a_err_char_out, a_err_ovf_out},
                     {pval, pcnt, perr});
            end
            if (ready_out) begin
               last_hs = cyc + 1;
               if (qa.size() == 0) begin
                  nchk++; nerr++;
                  $display("FAIL a_unexpected: result %0h with empty scoreboard", a_value_out);
               end else begin
                  e = qa.pop_front();
                  check("a_value", a_value_out, e.value);
                  check("a_count", a_digit_count_out, e.count);
                  check("a_err_char", a_err_char_out, e.ec);
                  check("a_err_ovf", a_err_ovf_out, e.eo);
               end
            end
         end
         pv = a_valid_out; pr = ready_out;
         pval = a_value_out; pcnt = a_digit_count_out; perr = {a_err_char_out, a_err_ovf_out};
      end
   end

   initial begin : mon_b
      bit pv = 0, pr = 0;
      logic [15:0] pval;
      logic [2:0]  pcnt;
      logic [1:0]  perr;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin pv = 0; continue; end
         if (b_valid_out) begin
            check("b_ready_in_done", b_ready_in, 0);
            if (pv && !pr) begin
               check("b_hold", {b_value_out, b_digit_count_out, b_err_char_out, b_err_ovf_out},
                     {pval, pcnt, perr});
            end
            if (ready_out) begin
               if (qb.size() == 0) begin
                  nchk++; nerr++;
                  $display("FAIL b_unexpected: result %0h with empty scoreboard", b_value_out);
               end else begin
                  e = qb.pop_front();
                  check("b_value", b_value_out, e.value);
                  check("b_count", b_digit_count_out, e.count);
                  check("b_err_char", b_err_char_out, e.ec);
                  check("b_err_ovf", b_err_ovf_out, e.eo);
               end
            end
         end
         pv = b_valid_out; pr = ready_out;
         pval = b_value_out; pcnt = b_digit_count_out; perr = {b_err_char_out, b_err_ovf_out};
      end
   end

   initial begin : stim
      int ac;
      int len;
      bit hx;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      @(negedge clk);

      send_str("1234", 0); send_char(8'h0D, 0, ac);
      send_char("d", 1, ac); send_char("E", 0, ac); send_char("a", 0, ac);
      send_char("D", 1, ac); send_char(8'h0A, 0, ac);
      send_str("12x4", 0); send_char(8'h20, 0, ac);
      send_str("123456789", 0); send_char(8'h0D, 0, ac);
      send_str("70000", 0); send_char(8'h0D, 0, ac);
      send_str("x1", 0); send_char(8'h0D, 0, ac);
      send_str("fFfF", 1); send_char(8'h0D, 1, ac);
      drain();

      // Consumer stalls for several cycles; the next character must wait.
      hold_rdy = 1'b1;
      send_str("7", 0); send_char(8'h0D, 0, ac);
      fork
         send_char("8", 0, ac);
         begin repeat (3) @(posedge clk); hold_rdy = 1'b0; end
      join
      check("accept_after_handshake", ac, last_hs + 1);
      send_char(8'h0D, 0, ac);
      drain();

      send_str("12", 0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      word.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_str("  5", 0); send_char(8'h0D, 0, ac);
      drain();

      for (int w = 0; w < 80; w++) begin
         repeat ($urandom_range(0, 2)) send_char(8'h20, $urandom_range(0, 1), ac);
         hx  = $urandom_range(0, 1);
         len = $urandom_range(1, 10);
         for (int i = 0; i < len; i++) begin
            send_char(gen_char(hx), (i == 0) ? hx : bit'($urandom_range(0, 1)), ac);
         end
         case ($urandom_range(0, 2))
            0: send_char(8'h0D, hx, ac);
            1: send_char(8'h0A, hx, ac);
            default: send_char(8'h20, hx, ac);
         endcase
      end
      drain();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
